// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// and the ALUOp / ALU B-source / PC-source select values.
package mips_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RD2      = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_IMM      = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: Moore outputs decoded from the state, with the
// FETCH write strobes qualified by mem_ready.
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t state;
    state_t next_state;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:     next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = MEM_ADDR;
                    OP_RTYPE:     next_state = R_EXEC;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    OP_ADDI:      next_state = ADDI_EXEC;
                    default:      next_state = FETCH;
                endcase
            end
            MEM_ADDR:  next_state = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ:  next_state = mem_ready ? MEM_WB : MEM_READ;
            MEM_WB:    next_state = FETCH;
            MEM_WRITE: next_state = mem_ready ? FETCH : MEM_WRITE;
            R_EXEC:    next_state = R_WB;
            R_WB:      next_state = FETCH;
            BRANCH:    next_state = FETCH;
            JUMP:      next_state = FETCH;
            ADDI_EXEC: next_state = ADDI_WB;
            ADDI_WB:   next_state = FETCH;
            default:   next_state = FETCH;
        endcase
    end

    // Everything, including the debug state view, reads as zero while reset is held.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RD2;
        PCSource    = PCSRC_ALU;
        ALUOp       = ALUOP_ADD;
        illegal_op  = 1'b0;
        state_o     = 4'd0;
        if (!reset) begin
            state_o = state;
            case (state)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                end
                DECODE: begin
                    ALUSrcB = SRCB_IMM_SHL2;
                    case (opcode)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
                        default:                                       illegal_op = 1'b1;
                    endcase
                end
                MEM_ADDR, ADDI_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                MEM_READ: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEM_WB: begin
                    RegWrite = 1'b1;
                    MemToReg = 1'b1;
                end
                MEM_WRITE: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                R_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_FUNCT;
                end
                R_WB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                end
                ADDI_WB: RegWrite = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each stimulus cycle queues the
// hand-computed {state_o, outputs}; a negedge monitor pops and compares.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemToReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, PCSource, ALUOp;
    logic [3:0] state_o;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOp(ALUOp), .illegal_op(illegal_op), .state_o(state_o)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] S_F = 4'd0, S_D = 4'd1, S_MA = 4'd2, S_MR = 4'd3,
                           S_MWB = 4'd4, S_MW = 4'd5, S_RE = 4'd6, S_RWB = 4'd7,
                           S_BR = 4'd8, S_J = 4'd9, S_AE = 4'd10, S_AWB = 4'd11;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000,
                           BAD = 6'b111111;

    // Bit order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemToReg
    //            RegDst RegWrite ALUSrcA ALUSrcB[2] PCSource[2] ALUOp[2] illegal_op
    localparam logic [16:0] O_ZERO  = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] O_FW    = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] O_FR    = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] O_DEC   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] O_DILL  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] O_MA    = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] O_MR    = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] O_MWB   = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] O_MW    = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] O_RE    = 17'b0_0_0_0_0_0_0_0_0_1_00_00_10_0;
    localparam logic [16:0] O_RWB   = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] O_BR    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] O_J     = 17'b1_0_0_0_0_0_0_0_0_0_00_10_00_0;
    localparam logic [16:0] O_AWB   = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

    typedef struct {
        logic [20:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [20:0] act;
            e   = exp_q.pop_front();
            act = {state_o, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                   MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal_op};
            vectors++;
            if (act !== e.val) begin
                miscompares++;
                $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                         e.name, act[20:17], act[16:0], e.val[20:17], e.val[16:0]);
            end
        end
    end

    task automatic step(input logic r, input logic [5:0] op, input logic mr,
                        input logic [3:0] st, input logic [16:0] outs, input string name);
        exp_t e;
        reset     = r;
        opcode    = op;
        mem_ready = mr;
        e.val     = {st, outs};
        e.name    = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = RT; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(1, LW, 1, S_F, O_ZERO, "reset_hold");

        // lw with memory always ready
        step(0, LW, 1, S_F,   O_FR,  "lw_fetch");
        step(0, LW, 1, S_D,   O_DEC, "lw_decode");
        step(0, LW, 1, S_MA,  O_MA,  "lw_memaddr");
        step(0, LW, 1, S_MR,  O_MR,  "lw_memread");
        step(0, LW, 1, S_MWB, O_MWB, "lw_memwb");

        // fetch stall of three cycles, then beq
        step(0, BEQ, 0, S_F, O_FW,  "stall_fetch1");
        step(0, BEQ, 0, S_F, O_FW,  "stall_fetch2");
        step(0, BEQ, 0, S_F, O_FW,  "stall_fetch3");
        step(0, BEQ, 1, S_F, O_FR,  "stall_fetch4");
        step(0, BEQ, 1, S_D, O_DEC, "beq_decode");
        step(0, BEQ, 1, S_BR, O_BR, "beq_branch");

        // illegal opcode falls straight back to fetch
        step(0, BAD, 1, S_F, O_FR,   "ill_fetch");
        step(0, BAD, 1, S_D, O_DILL, "ill_decode");
        step(0, BAD, 1, S_F, O_FR,   "ill_refetch");
        step(0, RT,  1, S_D, O_DEC,  "rt_decode");
        step(0, RT,  1, S_RE, O_RE,  "rt_exec");
        step(0, RT,  1, S_RWB, O_RWB, "rt_wb");

        // reset while a store waits on memory
        step(0, SW, 1, S_F,  O_FR,  "sw_fetch");
        step(0, SW, 1, S_D,  O_DEC, "sw_decode");
        step(0, SW, 1, S_MA, O_MA,  "sw_memaddr");
        step(0, SW, 0, S_MW, O_MW,  "sw_wait1");
        step(0, SW, 0, S_MW, O_MW,  "sw_wait2");
        step(1, SW, 0, S_F,  O_ZERO, "reset_in_memwrite");
        step(1, SW, 0, S_F,  O_ZERO, "reset_held");
        step(0, SW, 0, S_F,  O_FW,  "post_reset_fetch");

        // back-to-back R-type, sw, j, addi
        step(0, RT,   1, S_F,   O_FR,  "b2b_r_fetch");
        step(0, RT,   1, S_D,   O_DEC, "b2b_r_decode");
        step(0, RT,   1, S_RE,  O_RE,  "b2b_r_exec");
        step(0, RT,   1, S_RWB, O_RWB, "b2b_r_wb");
        step(0, SW,   1, S_F,   O_FR,  "b2b_sw_fetch");
        step(0, SW,   1, S_D,   O_DEC, "b2b_sw_decode");
        step(0, SW,   1, S_MA,  O_MA,  "b2b_sw_memaddr");
        step(0, SW,   1, S_MW,  O_MW,  "b2b_sw_memwrite");
        step(0, JMP,  1, S_F,   O_FR,  "b2b_j_fetch");
        step(0, JMP,  1, S_D,   O_DEC, "b2b_j_decode");
        step(0, JMP,  1, S_J,   O_J,   "b2b_j_jump");
        step(0, ADDI, 1, S_F,   O_FR,  "b2b_addi_fetch");
        step(0, ADDI, 1, S_D,   O_DEC, "b2b_addi_decode");
        step(0, ADDI, 1, S_AE,  O_MA,  "b2b_addi_exec");
        step(0, ADDI, 1, S_AWB, O_AWB, "b2b_addi_wb");

        // lw with one memory wait in MEM_READ; opcode ignored in MEM_READ
        step(0, LW,  1, S_F,   O_FR,  "lw2_fetch");
        step(0, LW,  1, S_D,   O_DEC, "lw2_decode");
        step(0, LW,  1, S_MA,  O_MA,  "lw2_memaddr");
        step(0, SW,  0, S_MR,  O_MR,  "lw2_memread_wait");
        step(0, BAD, 1, S_MR,  O_MR,  "lw2_memread_done");
        step(0, BAD, 1, S_MWB, O_MWB, "lw2_memwb");
        step(0, BAD, 0, S_F,   O_FW,  "lw2_back_to_fetch");

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
